uart_boot_ctrl: RTL and testbench
=================================

// Module: uart_boot_ctrl
// PURPOSE
//  Host-side command sequencer for the 1 Mb/s UART. It parses byte packets from the UART receiver and performs
//  word reads/writes on a memory port. It returns response bytes through the UART transmitter and holds the CPU
//  in reset until a GO command releases it at a chosen boot PC. Sits between the UART and the memory arbiter.
// PARAMETERS
//  TIMEOUT_CYCLES  2800  max clk cycles between bytes of one packet before abort (~10 byte times at 28 clk/bit)
// PORTS
//  clk          in   1   system clock; sole clock domain
//  rst          in   1   synchronous, active-high reset
//  rx_data      in   8   received byte from UART; valid when rx_valid=1
//  rx_valid     in   1   one-cycle strobe: new byte in rx_data
//  tx_data      out  8   byte to transmit; held stable while tx_en=1
//  tx_en        out  1   request UART to send tx_data; held until tx_done
//  tx_done      in   1   one-cycle pulse from UART (byte_done): byte + stop bit sent
//  mem_req      out  1   memory access request; held until mem_ack
//  mem_we       out  1   1=write, 0=read; valid with mem_req
//  mem_addr     out  32  word-aligned byte address
//  mem_wdata    out  32  write data
//  mem_rdata    in   32  read data; valid on mem_ack cycle
//  mem_ack      in   1   one-cycle completion pulse
//  cpu_hold     out  1   1 = CPU held in reset
//  boot_pc      out  32  PC the CPU starts from when cpu_hold falls
//  busy         out  1   1 whenever state != IDLE
//  err_overrun  out  1   sticky: rx byte arrived while not accepting; cleared only by rst
// BEHAVIOUR
//  Reset: tx_en=0, tx_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, boot_pc=0, busy=0,
//   err_overrun=0, state=IDLE, all counters 0. Reset mid-operation drops mem_req/tx_en on the next edge; the
//   partial packet is discarded and no response is sent.
//  Packets (multi-byte fields little-endian): 'W'=0x57 A0..A3 D0..D3 | 'R'=0x52 A0..A3 | 'G'=0x47 A0..A3.
//  Responses: ACK=0x06, NAK=0x15; R success returns 4 rdata bytes LE, no ACK.
//  States: IDLE -> ADDR -> (DATA for W) -> MEM -> TX -> IDLE; G skips MEM; errors go straight to TX with NAK.
//   IDLE: on rx_valid latch opcode; W/R/G -> ADDR (byte_cnt=0), any other value -> TX(NAK).
//   ADDR: shift 4 bytes into addr. After 4th: addr[1:0]!=0 on W/R -> TX(NAK), no memory access.
//     G with cpu_hold=0 -> TX(NAK). G otherwise -> boot_pc=addr, TX(ACK). W -> DATA. R -> MEM.
//   DATA: shift 4 bytes into mem_wdata, then -> MEM.
//   MEM: mem_req=1 on the cycle after the final packet byte's rx_valid edge. mem_addr/mem_we/mem_wdata stable
//     until mem_ack. On mem_ack: mem_req=0 next edge; rdata latched into the response shift reg; -> TX.
//     No timeout in MEM.
//   TX: tx_en=1 with tx_data=current response byte. On a cycle with tx_done=1, tx_en falls at that edge.
//     The next byte (if any) raises tx_en on the following edge; after the last byte -> IDLE. Response length 1 or 4.
//   GO release: cpu_hold falls on the edge that tx_en rises for the G ACK. cpu_hold never re-asserts except by rst.
//  Timeout: counter resets on every accepted rx byte and counts in ADDR/DATA only. On reaching TIMEOUT_CYCLES-1
//   -> TX(NAK) and the partial packet is discarded.
//  Overrun: rx_valid in MEM or TX -> byte dropped, err_overrun=1. rx_valid and timeout in the same cycle: the byte wins.
//  tx_done outside TX is ignored. mem_ack outside MEM is ignored.
// TESTING
//  1 W: 57 00 01 00 00 EF BE AD DE -> mem_req,we=1, addr=0x00000100, wdata=0xDEADBEEF; ack -> tx 0x06, IDLE.
//  2 R: 52 04 01 00 00, ack with rdata=0x12345678 -> tx 78,56,34,12, one tx_en rise per byte after each tx_done.
//  3 Misaligned W addr 0x00000102 / opcode 0x00 -> no mem_req, single tx 0x15, then a valid R completes.
//  4 Timeout: 57 00 then silence TIMEOUT_CYCLES -> tx 0x15, IDLE, busy=0; next packet parsed from its opcode.
//  5 G: 47 00 00 00 80 -> boot_pc=0x80000000, cpu_hold 1->0 on the tx_en edge, tx 0x06; a repeated G -> tx 0x15.
//  6 rx_valid during TX -> err_overrun=1, response unchanged; rst during MEM -> mem_req=0 next cycle, all reset values.

Source files
------------

// File: rtl/uart_boot_ctrl.sv
// UART host command sequencer: parses W/R/G byte packets, drives a word memory port,
// returns ACK/NAK/read data bytes and holds the CPU in reset until a GO command.
module uart_boot_ctrl #(
  parameter int TIMEOUT_CYCLES = 2800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic [31:0] boot_pc,
  output logic        busy,
  output logic        err_overrun
);

  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] OP_G    = 8'h47;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam int         TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_MEM, S_TX} state_t;

  state_t        state, state_nx;
  logic [7:0]    op;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] to_cnt;
  logic [31:0]   rsp_sh;
  logic [2:0]    rsp_left;

  logic [31:0]   addr_nx, wdata_nx, rsp_word;
  logic [2:0]    rsp_len;
  logic          last_byte, to_hit, ovr_ev, rsp_ld, go_fire, mem_start;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next-state and response selection
  always_comb begin
    state_nx = state;
    rsp_ld   = 1'b0;
    rsp_word = 32'h0;
    rsp_len  = 3'd1;
    go_fire  = 1'b0;
    case (state)
      S_IDLE: if (rx_valid) begin
        if (rx_data == OP_W || rx_data == OP_R || rx_data == OP_G) begin
          state_nx = S_ADDR;
        end else begin
          state_nx = S_TX; rsp_ld = 1'b1; rsp_word = {24'h0, RSP_NAK};
        end
      end
      S_ADDR: if (last_byte) begin
        if (op != OP_G && addr_nx[1:0] != 2'b00) begin
          state_nx = S_TX; rsp_ld = 1'b1; rsp_word = {24'h0, RSP_NAK};
        end else if (op == OP_G) begin
          state_nx = S_TX; rsp_ld = 1'b1;
          rsp_word = {24'h0, cpu_hold ? RSP_ACK : RSP_NAK};
          go_fire  = cpu_hold;
        end else begin
          state_nx = (op == OP_W) ? S_DATA : S_MEM;
        end
      end else if (to_hit) begin
        state_nx = S_TX; rsp_ld = 1'b1; rsp_word = {24'h0, RSP_NAK};
      end
      S_DATA: if (last_byte) begin
        state_nx = S_MEM;
      end else if (to_hit) begin
        state_nx = S_TX; rsp_ld = 1'b1; rsp_word = {24'h0, RSP_NAK};
      end
      S_MEM: if (mem_ack) begin
        state_nx = S_TX; rsp_ld = 1'b1;
        if (op == OP_R) begin
          rsp_word = mem_rdata; rsp_len = 3'd4;
        end else begin
          rsp_word = {24'h0, RSP_ACK};
        end
      end
      S_TX: if (tx_en && tx_done && rsp_left == 3'd1) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // decoded controls and combinational outputs
  always_comb begin
    busy      = (state != S_IDLE);
    addr_nx   = {rx_data, mem_addr[31:8]};
    wdata_nx  = {rx_data, mem_wdata[31:8]};
    last_byte = rx_valid && (byte_cnt == 2'd3);
    to_hit    = !rx_valid && (to_cnt == TO_LAST);
    ovr_ev    = rx_valid && (state == S_MEM || state == S_TX);
    mem_start = (state_nx == S_MEM) && (state != S_MEM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op          <= 8'h0;
      byte_cnt    <= 2'd0;
      to_cnt      <= '0;
      rsp_sh      <= 32'h0;
      rsp_left    <= 3'd0;
      tx_data     <= 8'h0;
      tx_en       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      cpu_hold    <= 1'b1;
      boot_pc     <= 32'h0;
      err_overrun <= 1'b0;
    end else begin
      if (ovr_ev) err_overrun <= 1'b1;
      case (state)
        S_IDLE: if (rx_valid) begin
          op       <= rx_data;
          byte_cnt <= 2'd0;
          to_cnt   <= '0;
        end
        S_ADDR, S_DATA: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            to_cnt   <= '0;
            if (state == S_ADDR) mem_addr  <= addr_nx;
            else                 mem_wdata <= wdata_nx;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_MEM: if (mem_ack) mem_req <= 1'b0;
        S_TX: begin
          // each byte is a full tx_en/tx_done handshake; the gap cycle loads the next byte
          if (tx_en && tx_done) begin
            tx_en    <= 1'b0;
            rsp_sh   <= rsp_sh >> 8;
            rsp_left <= rsp_left - 3'd1;
          end else if (!tx_en && rsp_left != 3'd0) begin
            tx_en   <= 1'b1;
            tx_data <= rsp_sh[7:0];
          end
        end
        default: ;
      endcase
      if (mem_start) begin
        mem_req <= 1'b1;
        mem_we  <= (op == OP_W);
      end
      if (rsp_ld) begin
        rsp_sh   <= rsp_word;
        rsp_left <= rsp_len;
        tx_en    <= 1'b1;
        tx_data  <= rsp_word[7:0];
      end
      if (go_fire) begin
        boot_pc  <= addr_nx;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Randomized bench for uart_boot_ctrl: packet-level reference model, memory and UART responders.
module tb_uart_boot_ctrl;
  localparam int TO = 200;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_done = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        cpu_hold, busy, err_overrun;
  logic [31:0] boot_pc;

  always #5 clk = ~clk;

  uart_boot_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cpu_hold(cpu_hold), .boot_pc(boot_pc), .busy(busy), .err_overrun(err_overrun)
  );

  typedef logic [7:0] bq_t[$];

  int          n_vec = 0, n_err = 0;
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] m_mem   [logic [31:0]];
  bit          slv_en = 1'b1;
  int          slv_w = 0, tx_w = 0, tx_rises = 0;
  logic [7:0]  tx_q[$];
  logic [64:0] mem_log[$];
  logic        hold_edge_ok = 1'b0, ptx = 1'b0, phold = 1'b1;
  logic        m_hold = 1'b1;
  logic [31:0] m_boot = 32'h0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC3A5_1E69;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory slave: random ack latency, records every completed access
  initial forever begin
    tick();
    if (mem_ack) mem_ack = 1'b0;
    else if (mem_req && slv_en) begin
      if (slv_w > 0) slv_w--;
      else begin
        mem_log.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
        if (mem_we) slv_mem[mem_addr] = mem_wdata;
        mem_rdata = slv_mem.exists(mem_addr) ? slv_mem[mem_addr] : dflt(mem_addr);
        mem_ack   = 1'b1;
        slv_w     = $urandom_range(0, 4);
      end
    end
  end

  // UART transmitter: random byte time, counts tx_en rises, watches the GO release edge
  initial forever begin
    tick();
    if (tx_en && !ptx) tx_rises++;
    if (phold && !cpu_hold) hold_edge_ok = tx_en && !ptx && (tx_data == 8'h06);
    ptx = tx_en; phold = cpu_hold;
    if (tx_done) tx_done = 1'b0;
    else if (tx_en) begin
      if (tx_w > 0) tx_w--;
      else begin
        tx_q.push_back(tx_data);
        tx_done = 1'b1;
        tx_w    = $urandom_range(0, 5);
      end
    end
  end

  function automatic bq_t pk_a(input logic [7:0] op, input logic [31:0] a);
    bq_t p;
    p.push_back(op);
    for (int i = 0; i < 4; i++) p.push_back(a[8*i +: 8]);
    return p;
  endfunction

  function automatic bq_t pk_w(input logic [31:0] a, input logic [31:0] d);
    bq_t p = pk_a(8'h57, a);
    for (int i = 0; i < 4; i++) p.push_back(d[8*i +: 8]);
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    chk("idle_wait", busy, 1'b0);
  endtask

  // model: response bytes and memory effect from the packet's meaning alone
  task automatic run_pkt(input bq_t pk, input bit ovr);
    logic [7:0]  exp[$];
    logic [64:0] etx[$];
    logic [31:0] a, d;
    int r0, n;
    a = (pk.size() >= 5) ? {pk[4], pk[3], pk[2], pk[1]} : 32'h0;
    case (pk[0])
      8'h57: if (a[1:0] != 2'b00) exp.push_back(8'h15);
        else begin
          d = {pk[8], pk[7], pk[6], pk[5]};
          m_mem[a] = d;
          etx.push_back({1'b1, a, d});
          exp.push_back(8'h06);
        end
      8'h52: if (a[1:0] != 2'b00) exp.push_back(8'h15);
        else begin
          d = m_mem.exists(a) ? m_mem[a] : dflt(a);
          etx.push_back({1'b0, a, 32'h0});
          for (int i = 0; i < 4; i++) exp.push_back(d[8*i +: 8]);
        end
      8'h47: if (m_hold) begin exp.push_back(8'h06); m_hold = 1'b0; m_boot = a; end
        else exp.push_back(8'h15);
      default: exp.push_back(8'h15);
    endcase
    tx_q.delete(); mem_log.delete(); r0 = tx_rises;
    for (int i = 0; i < pk.size(); i++) begin
      send_byte(pk[i]);
      if (i != pk.size() - 1) repeat ($urandom_range(0, 3)) tick();
    end
    if (ovr) begin
      n = 0;
      while (!tx_en && n < 100) begin tick(); n++; end
      chk("ovr_in_tx", tx_en, 1'b1);
      send_byte(8'hA5);
    end
    wait_idle();
    chk("rsp_len", tx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++) chk("rsp_byte", tx_q[i], exp[i]);
    chk("tx_rises", tx_rises - r0, exp.size());
    chk("mem_cnt", mem_log.size(), etx.size());
    if (etx.size() == 1 && mem_log.size() == 1) chk("mem_txn", mem_log[0], etx[0]);
    chk("cpu_hold", cpu_hold, m_hold);
    chk("boot_pc", boot_pc, m_boot);
  endtask

  initial begin
    bq_t p;
    int n, kind;
    logic [31:0] a;
    logic [7:0]  b;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_bootpc", boot_pc, 32'h0);
    chk("rst_ovr", err_overrun, 1'b0);
    tick();

    run_pkt(pk_w(32'h0000_0100, 32'hDEAD_BEEF), 1'b0);
    slv_mem[32'h104] = 32'h1234_5678; m_mem[32'h104] = 32'h1234_5678;
    run_pkt(pk_a(8'h52, 32'h0000_0104), 1'b0);
    run_pkt(pk_a(8'h57, 32'h0000_0102), 1'b0);
    p.delete(); p.push_back(8'h00);
    run_pkt(p, 1'b0);
    run_pkt(pk_a(8'h52, 32'h0000_0100), 1'b0);

    // inter-byte silence aborts the packet
    tx_q.delete(); mem_log.delete();
    send_byte(8'h57); send_byte(8'h00);
    n = 0;
    while (!tx_en && n < TO + 50) begin tick(); n++; end
    chk("to_latency", (n >= TO - 2 && n <= TO + 1), 1'b1);
    wait_idle();
    chk("to_rsp_len", tx_q.size(), 1);
    if (tx_q.size() > 0) chk("to_rsp", tx_q[0], 8'h15);
    chk("to_no_mem", mem_log.size(), 0);
    run_pkt(pk_a(8'h52, 32'h0000_0104), 1'b0);

    run_pkt(pk_a(8'h47, 32'h8000_0000), 1'b0);
    chk("go_edge", hold_edge_ok, 1'b1);
    run_pkt(pk_a(8'h47, 32'h0000_0040), 1'b0);

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 8);
      a = 32'h100 + ($urandom_range(0, 15) << 2);
      case (kind)
        0, 1, 2: p = pk_w(a, $urandom);
        3, 4, 5: p = pk_a(8'h52, a);
        6:       p = pk_a(8'h47, $urandom);
        7: begin
          do b = 8'($urandom); while (b == 8'h57 || b == 8'h52 || b == 8'h47);
          p.delete(); p.push_back(b);
        end
        default: p = pk_a(($urandom_range(0, 1) != 0) ? 8'h57 : 8'h52,
                          a | 32'($urandom_range(1, 3)));
      endcase
      run_pkt(p, 1'b0);
    end
    chk("no_ovr_yet", err_overrun, 1'b0);

    run_pkt(pk_a(8'h52, 32'h0000_0104), 1'b1);
    chk("ovr_flag", err_overrun, 1'b1);

    // reset while a write is waiting for its ack
    slv_en = 1'b0;
    p = pk_w(32'h0000_0140, 32'h1122_3344);
    for (int i = 0; i < p.size(); i++) send_byte(p[i]);
    n = 0;
    while (!mem_req && n < 20) begin tick(); n++; end
    chk("mem_req_up", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    chk("mrst_req", mem_req, 1'b0);
    chk("mrst_we", mem_we, 1'b0);
    chk("mrst_addr", mem_addr, 32'h0);
    chk("mrst_wdata", mem_wdata, 32'h0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_tx_en", tx_en, 1'b0);
    chk("mrst_tx_data", tx_data, 8'h0);
    chk("mrst_hold", cpu_hold, 1'b1);
    chk("mrst_bootpc", boot_pc, 32'h0);
    chk("mrst_ovr", err_overrun, 1'b0);
    rst = 1'b0; slv_en = 1'b1;
    m_hold = 1'b1; m_boot = 32'h0;
    tx_q.delete(); mem_log.delete();
    repeat (20) tick();
    chk("mrst_no_rsp", tx_q.size(), 0);
    chk("mrst_no_mem", mem_log.size(), 0);
    run_pkt(pk_a(8'h52, 32'h0000_0140), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
